load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  start a memory operation; sampled only in IDLE.
REQ-004 opcode  in  6  MIPS opcode: LB 0x20, LH 0x21, LWL 0x22, LW 0x23, LBU 0x24, LHU 0x25, LWR 0x26, SB 0x28, SH 0x29, SW 0x2B.
REQ-005 addr  in  32  effective byte address (base + sign-extended offset).
REQ-006 rt_data  in  32  current rt value: store source for SB/SH/SW, merge source for LWL/LWR.
REQ-007 stall  out  1  high while an operation is accepted and not yet done; holds the CPU pipeline.
REQ-008 done  out  1  one-cycle pulse; load_data valid for loads.
REQ-009 load_data  out  32  extended or merged load result.
REQ-010 align_err  out  1  one-cycle pulse in place of done for a misaligned access.
REQ-011 address  out  32  bus word address; bits [1:0] always 0.
REQ-012 read / write  out  1 each  bus strobes; never both high.
REQ-013 byteenable  out  4  little-endian byte lanes; lane n = bits [8n+7:8n].
REQ-014 writedata  out  32  bus write data.
REQ-015 readdata  in  32  bus read data; valid in the cycle waitrequest is low with read high.
REQ-016 waitrequest  in  1  bus busy; strobes, address, byteenable and writedata SHALL hold while it is high.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE.
REQ-018 IDLE: req_valid with a load/store opcode and legal alignment -> latch opcode, addr[1:0] and rt_data; go to ACCESS. stall SHALL assert combinationally in the same cycle.
REQ-019 Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; others are unrestricted. Violation -> no bus cycle, align_err pulses next cycle, return to IDLE.
REQ-020 Opcodes not listed under REQ-004 SHALL be ignored: stay IDLE, stall low.
REQ-021 ACCESS: drive address={addr[31:2],00}; read or write per opcode; remain while waitrequest=1; on waitrequest=0 capture readdata (loads) and go to DONE.
REQ-022 DONE: done=1 for one cycle, stall=0, then IDLE; a req_valid in DONE SHALL be ignored.
REQ-023 Minimum latency from accept to done is 2 cycles (waitrequest low).
REQ-024 Loads: byteenable=1111.
REQ-025 SB: byteenable=1<<off; writedata={4{rt[7:0]}}.
REQ-026 SH: byteenable=0011 for off 0 and 1100 for off 2; writedata={2{rt[15:0]}}.
REQ-027 SW: byteenable=1111; writedata=rt.
REQ-028 LB/LBU: select byte lane off; sign-extend for LB, zero-extend for LBU. LH/LHU: select half off[1]; sign-extend for LH, zero-extend for LHU. LW: word unchanged.
REQ-029 LWL, m=readdata, r=latched rt: off0 {m[7:0],r[23:0]}; off1 {m[15:0],r[15:0]}; off2 {m[23:0],r[7:0]}; off3 m.
REQ-030 LWR: off0 m; off1 {r[31:24],m[31:8]}; off2 {r[31:16],m[31:16]}; off3 {r[31:8],m[31:24]}.
REQ-031 load_data SHALL hold its last value until the next load completes.

Reset
REQ-032 Reset SHALL force IDLE. stall, done, align_err, read and write go to 0; address, byteenable, writedata and load_data go to 0.
REQ-033 Reset in ACCESS SHALL abort the operation and drop the strobes next cycle, with no done pulse.

Structure
REQ-034 Opcode constants and the state enum SHALL live in the shared package mips_pkg.
REQ-035 Sub-module load_extend SHALL be a combinational lane select, extend and LWL/LWR merge; FSM and bus drive stay in the top module.

Verification
REQ-036 LW at 0x100 with readdata 0xDEADBEEF and waitrequest 0 -> read=1, address 0x100, done at +2 cycles, load_data 0xDEADBEEF.
REQ-037 LB at 0x103, readdata 0x80112233 -> load_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 SH at 0x202, rt 0x1234ABCD, waitrequest high for 3 cycles -> address 0x200, be 1100, writedata 0xABCDABCD held stable, done at +5 cycles.
REQ-039 LWL at 0x301, rt 0x11223344, m 0xAABBCCDD -> 0xCCDD3344; LWR at 0x301 -> 0x11AABBCC.
REQ-040 LW at 0x102 -> align_err pulse, read never asserted; SB at 0x102 -> be 0100, done.
REQ-041 Reset asserted during ACCESS with waitrequest high -> IDLE next cycle, strobes 0, no done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS load/store unit.
// Holds the memory opcode constants, the FSM state type and small helpers
// that classify opcodes and build the store byte lanes and write data.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Word ops need a word boundary, halfword ops an even address;
    // byte ops and the unaligned LWL/LWR pair accept any offset.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:          return (off == 2'b00);
            OP_LH, OP_LHU, OP_SH:  return !off[0];
            default:               return 1'b1;
        endcase
    endfunction

    // Loads always read the full word; lane selection happens on return.
    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b0001 << off;
            OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the source across all lanes lets byteenable alone pick
    // the destination, so no shifting is needed on the write path.
    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
        case (op)
            OP_SB:   return {4{rt[7:0]}};
            OP_SH:   return {2{rt[15:0]}};
            OP_SW:   return rt;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter.
// Selects the addressed byte/halfword of the bus word and sign- or
// zero-extends it, or merges memory with the old rt value for LWL/LWR.
//   opcode   : latched load opcode
//   offset   : latched byte offset addr[1:0]
//   mem_data : bus read data (full little-endian word)
//   rt_data  : latched rt value, merge source for LWL/LWR
//   result   : formatted register write value
module load_extend
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_data,
    input  logic [31:0] rt_data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            2'd3: byte_sel = mem_data[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // LWL fills the register from the top down, LWR from the bottom up;
    // the bytes not covered by memory keep their old rt contents.
    always_comb begin
        result = mem_data;
        case (opcode)
            OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: result = {24'h000000, byte_sel};
            OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            OP_LHU: result = {16'h0000, half_sel};
            OP_LWL: begin
                case (offset)
                    2'd0: result = {mem_data[7:0],  rt_data[23:0]};
                    2'd1: result = {mem_data[15:0], rt_data[15:0]};
                    2'd2: result = {mem_data[23:0], rt_data[7:0]};
                    default: result = mem_data;
                endcase
            end
            OP_LWR: begin
                case (offset)
                    2'd1: result = {rt_data[31:24], mem_data[31:8]};
                    2'd2: result = {rt_data[31:16], mem_data[31:16]};
                    2'd3: result = {rt_data[31:8],  mem_data[31:24]};
                    default: result = mem_data;
                endcase
            end
            default: result = mem_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: accepts one memory operation at a time from the
// pipeline, runs a single bus cycle and returns formatted load data.
//   clk, reset                : clock, synchronous active-high reset
//   req_valid, opcode, addr   : operation request (sampled in IDLE only)
//   rt_data                   : store source / LWL-LWR merge source
//   stall, done, align_err    : pipeline handshake
//   load_data                 : load result, held until the next load
//   address, read, write,
//   byteenable, writedata     : bus master outputs (held during waitrequest)
//   readdata, waitrequest     : bus slave inputs
module load_store_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        align_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    lsu_state_t  state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] rt_q;
    logic        mem_op;
    logic        accept;
    logic        misalign;
    logic [31:0] ext_result;

    always_comb begin
        mem_op   = is_load(opcode) || is_store(opcode);
        accept   = req_valid && mem_op && is_aligned(opcode, addr[1:0]);
        misalign = req_valid && mem_op && !is_aligned(opcode, addr[1:0]);
    end

    // The pipeline must freeze in the very cycle the request is accepted,
    // so stall includes the combinational accept term.
    always_comb begin
        stall = (state == S_ACCESS) || ((state == S_IDLE) && accept);
    end

    load_extend u_load_extend (
        .opcode   (op_q),
        .offset   (off_q),
        .mem_data (readdata),
        .rt_data  (rt_q),
        .result   (ext_result)
    );

    // Bus outputs are loaded once on accept and left untouched while the
    // slave holds waitrequest, which gives the required stability for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= 6'd0;
            off_q      <= 2'd0;
            rt_q       <= 32'd0;
            done       <= 1'b0;
            align_err  <= 1'b0;
            load_data  <= 32'd0;
            address    <= 32'd0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'd0;
            writedata  <= 32'd0;
        end else begin
            done      <= 1'b0;
            align_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= opcode;
                        off_q      <= addr[1:0];
                        rt_q       <= rt_data;
                        address    <= {addr[31:2], 2'b00};
                        read       <= is_load(opcode);
                        write      <= is_store(opcode);
                        byteenable <= store_be(opcode, addr[1:0]);
                        writedata  <= store_data(opcode, rt_data);
                        state      <= S_ACCESS;
                    end else if (misalign) begin
                        align_err <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (is_load(op_q)) begin
                            load_data <= ext_result;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit.
// Stimulus tasks push the hand-computed response of each operation into a
// queue; an independent monitor pops and compares whenever done or
// align_err pulses, also checking the bus cycle it saw for that operation.
module tb_load_store_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        align_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'd0;
    logic        waitrequest = 1'b0;

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .opcode      (opcode),
        .addr        (addr),
        .rt_data     (rt_data),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .align_err   (align_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        string       name;
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        bit          exp_read;
        bit          exp_write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          latency;
        int          issue_cycle;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: tracks the bus cycle of the current operation and scores it
    // against the scoreboard entry when the response pulse appears.
    bit          seen_read, seen_write, prev_strobe, prev_wait;
    logic [31:0] seen_addr, seen_wd, prev_addr, prev_wd;
    logic [3:0]  seen_be, prev_be;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen_read = 0; seen_write = 0; prev_strobe = 0; prev_wait = 0;
        end else begin
            if (read || write) begin
                check_output("rw_exclusive", 32'(read && write), 32'd0);
                if (prev_strobe && prev_wait) begin
                    check_output("hold_address", address, prev_addr);
                    check_output("hold_be", 32'(byteenable), 32'(prev_be));
                    check_output("hold_wdata", writedata, prev_wd);
                end
                seen_read  = seen_read  | read;
                seen_write = seen_write | write;
                seen_addr  = address;
                seen_be    = byteenable;
                seen_wd    = writedata;
            end
            if (done || align_err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_response: got done=%0b align_err=%0b, required none", done, align_err);
                end else begin
                    e = sb.pop_front();
                    check_output({e.name, " align_err"}, 32'(align_err), 32'(e.is_err));
                    check_output({e.name, " done"}, 32'(done), 32'(!e.is_err));
                    check_output({e.name, " latency"}, 32'(cycle - e.issue_cycle), 32'(e.latency));
                    check_output({e.name, " read_seen"}, 32'(seen_read), 32'(e.exp_read));
                    check_output({e.name, " write_seen"}, 32'(seen_write), 32'(e.exp_write));
                    if (e.exp_read || e.exp_write) begin
                        check_output({e.name, " address"}, seen_addr, e.addr);
                        check_output({e.name, " be"}, 32'(seen_be), 32'(e.be));
                        check_output({e.name, " wdata"}, seen_wd, e.wd);
                    end
                    if (e.chk_data)
                        check_output({e.name, " load_data"}, load_data, e.data);
                end
                seen_read = 0;
                seen_write = 0;
            end
            prev_strobe = read || write;
            prev_wait   = waitrequest;
            prev_addr   = address;
            prev_be     = byteenable;
            prev_wd     = writedata;
        end
    end

    // Issues one operation at posedge+1 and returns at posedge+1 once the
    // operation has had time to complete; nwait = waitrequest-high cycles.
    task automatic apply_stimulus(
        input string name, input logic [5:0] op, input logic [31:0] a,
        input logic [31:0] rt, input logic [31:0] rd, input int nwait,
        input bit is_err, input bit chk, input logic [31:0] data,
        input bit er, input bit ew, input logic [31:0] eaddr,
        input logic [3:0] ebe, input logic [31:0] ewd, input int lat);
        exp_t e;
        e.name = name; e.is_err = is_err; e.chk_data = chk; e.data = data;
        e.exp_read = er; e.exp_write = ew; e.addr = eaddr; e.be = ebe;
        e.wd = ewd; e.latency = lat; e.issue_cycle = cycle;
        sb.push_back(e);
        opcode = op; addr = a; rt_data = rt; readdata = rd;
        waitrequest = (nwait > 0);
        req_valid = 1'b1;
        #1;
        check_output({name, " stall"}, 32'(stall), 32'(!is_err));
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (nwait) begin @(posedge clk); #1; end
        waitrequest = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        exp_t e;
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset stall", 32'(stall), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        check_output("reset align_err", 32'(align_err), 32'd0);
        check_output("reset strobes", 32'({read, write}), 32'd0);
        check_output("reset address", address, 32'd0);
        check_output("reset be", 32'(byteenable), 32'd0);
        check_output("reset wdata", writedata, 32'd0);
        check_output("reset load_data", load_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //             name     op      addr          rt            readdata    nw err chk data        rd wr addr         be       wdata        lat
        apply_stimulus("lw",    OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0,        2);
        apply_stimulus("lb",    OP_LB,  32'h103, 32'h0,        32'h80112233, 0, 0, 1, 32'hFFFFFF80, 1, 0, 32'h100, 4'b1111, 32'h0,        2);
        apply_stimulus("lbu",   OP_LBU, 32'h103, 32'h0,        32'h80112233, 0, 0, 1, 32'h00000080, 1, 0, 32'h100, 4'b1111, 32'h0,        2);
        apply_stimulus("sh",    OP_SH,  32'h202, 32'h1234ABCD, 32'h0,        3, 0, 1, 32'h00000080, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 5);
        apply_stimulus("lwl1",  OP_LWL, 32'h301, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'hCCDD3344, 1, 0, 32'h300, 4'b1111, 32'h0,        2);
        apply_stimulus("lwr1",  OP_LWR, 32'h301, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h11AABBCC, 1, 0, 32'h300, 4'b1111, 32'h0,        2);
        apply_stimulus("lw_mis",OP_LW,  32'h102, 32'h0,        32'h0,        0, 1, 1, 32'h11AABBCC, 0, 0, 32'h0,   4'b0000, 32'h0,        1);
        apply_stimulus("sb",    OP_SB,  32'h102, 32'h000000A5, 32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h100, 4'b0100, 32'hA5A5A5A5, 2);
        apply_stimulus("lh",    OP_LH,  32'h102, 32'h0,        32'h80011234, 0, 0, 1, 32'hFFFF8001, 1, 0, 32'h100, 4'b1111, 32'h0,        2);
        apply_stimulus("lhu",   OP_LHU, 32'h102, 32'h0,        32'h80011234, 0, 0, 1, 32'h00008001, 1, 0, 32'h100, 4'b1111, 32'h0,        2);
        apply_stimulus("sw",    OP_SW,  32'h010, 32'hCAFEF00D, 32'h0,        1, 0, 1, 32'h00008001, 0, 1, 32'h010, 4'b1111, 32'hCAFEF00D, 3);
        apply_stimulus("lwl0",  OP_LWL, 32'h300, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'hDD223344, 1, 0, 32'h300, 4'b1111, 32'h0,        2);
        apply_stimulus("lwr3",  OP_LWR, 32'h303, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h112233AA, 1, 0, 32'h300, 4'b1111, 32'h0,        2);
        apply_stimulus("sh_mis",OP_SH,  32'h201, 32'h0,        32'h0,        0, 1, 0, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        1);

        // Unlisted opcode: nothing may happen at all.
        opcode = 6'h0F; addr = 32'h0; req_valid = 1'b1;
        #1;
        check_output("bad_op stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("bad_op strobes", 32'({read, write}), 32'd0);
        repeat (3) begin @(posedge clk); #1; end

        // A request presented during DONE must be dropped.
        e.name = "lw_done_req"; e.is_err = 0; e.chk_data = 1; e.data = 32'h12345678;
        e.exp_read = 1; e.exp_write = 0; e.addr = 32'h40; e.be = 4'b1111; e.wd = 32'h0;
        e.latency = 2; e.issue_cycle = cycle;
        sb.push_back(e);
        opcode = OP_LW; addr = 32'h40; readdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        opcode = OP_SW; addr = 32'h80; rt_data = 32'h55555555; req_valid = 1'b1;
        #1;
        check_output("done_req stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("done_req strobes", 32'({read, write}), 32'd0);
        repeat (4) begin @(posedge clk); #1; end

        // Reset during a stalled bus cycle aborts without a done pulse.
        opcode = OP_LW; addr = 32'h100; readdata = 32'h0; waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_output("abort read_before", 32'(read), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        check_output("abort strobes", 32'({read, write}), 32'd0);
        check_output("abort stall", 32'(stall), 32'd0);
        check_output("abort done", 32'(done), 32'd0);
        check_output("abort load_data", load_data, 32'd0);
        repeat (4) begin @(posedge clk); #1; end

        check_output("pending_responses", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
